stream_demux_1to2: RTL
======================

// Module: stream_demux_1to2
// PURPOSE
//  Routes one valid/ready data stream to one of two consumer channels, selected per beat by select_i.
//  Each channel is buffered by a 2-entry FIFO, so a stalled consumer never blocks the other channel.
//  Sits between a pipeline stage producer and two downstream consumers in the CPU datapath.
// PARAMETERS
//  size   32  data width in bits of the input and both output channels
//  CNT_W  16  width of each per-channel beat counter; used only with STREAM_DEMUX_CNT_EN
// PORTS
//  clk_i      in   1     clock; all state updates on the rising edge
//  rst_i      in   1     reset, asynchronous, active-low
//  valid_i    in   1     input beat valid
//  ready_o    out  1     input beat accepted when valid_i & ready_o
//  data_i     in   size  input beat data
//  select_i   in   1     target channel for the current beat: 0 -> ch0, 1 -> ch1
//  valid0_o   out  1     ch0 head entry valid
//  ready0_i   in   1     ch0 consumer ready
//  data0_o    out  size  ch0 head data
//  valid1_o   out  1     ch1 head entry valid
//  ready1_i   in   1     ch1 consumer ready
//  data1_o    out  size  ch1 head data
//  cnt0_o     out  CNT_W ch0 accepted-beat count (STREAM_DEMUX_CNT_EN only)
//  cnt1_o     out  CNT_W ch1 accepted-beat count (STREAM_DEMUX_CNT_EN only)
// BEHAVIOUR
//  Reset (rst_i=0, asynchronous): both FIFOs empty; valid0_o=valid1_o=0; data0_o=data1_o=0; counts=0.
//  ready_o = ~full[select_i]. full is derived from registered occupancy only, with no pop pass-through.
//   A beat into a full channel stalls even if that channel pops in the same cycle.
//  push[c] = valid_i & ready_o & (select_i==c). The beat is written to the tail of FIFO c.
//  pop[c] = valid_c_o & ready_c_i. The head advances.
//  Occupancy per channel is 0..2. Push only: +1. Pop only: -1. Push and pop together: unchanged.
//  Latency: a beat pushed in cycle N appears at valid_c_o/data_c_o in cycle N+1 if that FIFO was empty.
//  Order is preserved within each channel. There is no ordering between channels.
//  valid_c_o = (occupancy_c != 0). data_c_o = head entry, and holds stable while valid & ~ready.
//  Pointers are 1 bit and wrap 1->0.
//  Empty data_c_o shows the last popped value (0 after reset). It is don't-care to consumers.
//  select_i and data_i are sampled only when valid_i=1. ready_o is combinational on select_i.
//  Reset asserted mid-transfer: all buffered beats are discarded and outputs return to reset values at once.
// CONFIGURATION
//  Macro STREAM_DEMUX_CNT_EN is defined:
//   - cnt0_o/cnt1_o count push[0]/push[1].
//   - Each counter increments by 1 per accepted beat and wraps from 2^CNT_W-1 to 0.
//   - Counters are reset only by rst_i.
//  Macro STREAM_DEMUX_CNT_EN is undefined:
//   - cnt0_o/cnt1_o are tied to 0.
//   - No counter flops are generated.
//   - The port list is unchanged.
// STRUCTURE
//  Shared package/header stream_demux_defs:
//   - CH0=1'b0, CH1=1'b1
//   - FIFO_DEPTH=2
//   - OCC_W=2 (occupancy width)
//  Sub-module demux_fifo2: 2-entry synchronous FIFO.
//   - Interface: push/pop/data_in/data_out/empty/full, clk_i, rst_i.
//   - Instantiated once per channel.
//  Top level: select decode, ready_o mux, optional counters.
// TESTING
//  1 Reset, then ch0 push 0xA5A5A5A5 with ready0_i=1:
//    valid0_o=1 and data0_o=0xA5A5A5A5 one cycle later; popped next edge; valid1_o stays 0.
//  2 ready0_i=0, push 3 beats to ch0:
//    the first 2 are accepted; ready_o=0 for the 3rd.
//    Meanwhile a beat with select_i=1 is accepted and delivered on ch1.
//  3 ch1 holds 1 entry; push and pop ch1 in the same cycle:
//    occupancy stays 1; data1_o shows the new beat next cycle; order is preserved.
//  4 ch0 full; ready0_i=1 and a ch0 push in the same cycle:
//    the push stalls (ready_o=0); the pop completes; the push is accepted the following cycle.
//  5 Drop rst_i mid-stream with both FIFOs full:
//    valid0_o=valid1_o=0 immediately (before the next edge); ready_o=1 after release.
//  6 With STREAM_DEMUX_CNT_EN and CNT_W=4, push 17 beats to ch1:
//    cnt1_o=1 (wrapped) and cnt0_o=0.
//    Without the macro, both counts read 0.

Source files
------------

// File: rtl/stream_demux_defs.sv
// Shared definitions for the 1-to-2 stream demultiplexer.
// Channel ids, FIFO depth and occupancy arithmetic.
package stream_demux_defs;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;
   localparam int FIFO_DEPTH = 2;
   localparam int OCC_W = 2;

   typedef logic [OCC_W-1:0] occ_t;

   typedef struct packed {
      logic push;
      logic pop;
   } fifo_ctl_t;

   function automatic occ_t occ_next(
      input occ_t occ,
      input fifo_ctl_t ctl
   );
      occ_t nxt;
      nxt = occ;
      unique case ({ctl.push, ctl.pop})
         2'b10:   nxt = occ + occ_t'(1);
         2'b01:   nxt = occ - occ_t'(1);
         default: nxt = occ;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/demux_fifo2.sv
// 2-entry synchronous FIFO with 1-bit wrapping pointers.
// When empty, data_out shows the most recently popped entry.
module demux_fifo2
   import stream_demux_defs::*;
#(
   parameter int size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push,
   input  logic            pop,
   input  logic [size-1:0] data_in,
   output logic [size-1:0] data_out,
   output logic            empty,
   output logic            full
);

   logic [size-1:0] mem [FIFO_DEPTH];
   logic            wr_ptr;
   logic            rd_ptr;
   occ_t            occ;
   fifo_ctl_t       ctl;

   assign empty = (occ == '0);
   assign full  = (occ == occ_t'(FIFO_DEPTH));

   always_comb begin
      ctl      = '0;
      ctl.push = push & ~full;
      ctl.pop  = pop & ~empty;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= '0;
      end else begin
         if (ctl.push) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= ~wr_ptr;
         end
         if (ctl.pop) begin
            rd_ptr <= ~rd_ptr;
         end
         occ <= occ_next(occ, ctl);
      end
   end

   // the slot behind rd_ptr holds the last popped beat while empty
   assign data_out = empty ? mem[~rd_ptr] : mem[rd_ptr];

endmodule

// File: rtl/stream_demux_1to2.sv
// Routes one valid/ready stream to one of two buffered channels.
// Optional beat counters: define STREAM_DEMUX_CNT_EN.
module stream_demux_1to2
   import stream_demux_defs::*;
#(
   parameter int size  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [size-1:0]  data_i,
   input  logic             select_i,
   output logic             valid0_o,
   input  logic             ready0_i,
   output logic [size-1:0]  data0_o,
   output logic             valid1_o,
   input  logic             ready1_i,
   output logic [size-1:0]  data1_o,
   output logic [CNT_W-1:0] cnt0_o,
   output logic [CNT_W-1:0] cnt1_o
);

   logic empty0, full0;
   logic empty1, full1;
   logic push0, push1;
   logic pop0, pop1;

   // full comes from registered occupancy only; no pop pass-through
   always_comb begin
      ready_o = 1'b0;
      unique case (select_i)
         CH0: ready_o = ~full0;
         CH1: ready_o = ~full1;
         default: ready_o = 1'b0;
      endcase
   end

   assign push0 = valid_i & ready_o & (select_i == CH0);
   assign push1 = valid_i & ready_o & (select_i == CH1);

   assign valid0_o = ~empty0;
   assign valid1_o = ~empty1;
   assign pop0     = valid0_o & ready0_i;
   assign pop1     = valid1_o & ready1_i;

   demux_fifo2 #(
      .size(size)
   ) u_fifo0 (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push    (push0),
      .pop     (pop0),
      .data_in (data_i),
      .data_out(data0_o),
      .empty   (empty0),
      .full    (full0)
   );

   demux_fifo2 #(
      .size(size)
   ) u_fifo1 (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push    (push1),
      .pop     (pop1),
      .data_in (data_i),
      .data_out(data1_o),
      .empty   (empty1),
      .full    (full1)
   );

`ifdef STREAM_DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt0_q;
   logic [CNT_W-1:0] cnt1_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (push0) cnt0_q <= cnt0_q + CNT_W'(1);
         if (push1) cnt1_q <= cnt1_q + CNT_W'(1);
      end
   end

   assign cnt0_o = cnt0_q;
   assign cnt1_o = cnt1_q;
`else
   assign cnt0_o = '0;
   assign cnt1_o = '0;
`endif

endmodule
